// File: rtl/mem_bank_arbiter_if.sv
// Request/response and SRAM front-end signal bundle for mem_bank_arbiter.
// slave is the arbiter's view; master is the requester + front-end side.
interface mem_bank_arbiter_if;
  logic        REQ0;
  logic        REQ1;
  logic        WE0;
  logic        WE1;
  logic [10:0] ADDR0;
  logic [10:0] ADDR1;
  logic [7:0]  WDATA0;
  logic [7:0]  WDATA1;
  logic        GNT0;
  logic        GNT1;
  logic        RVALID0;
  logic        RVALID1;
  logic [7:0]  RDATA;
  logic        BUSY;
  logic [10:0] M_ADDR;
  logic        M_CE;
  logic        M_CSB;
  logic        M_WEB;
  logic        M_OEB;
  logic [7:0]  M_IDATA;
  logic [7:0]  M_RDATA;

  modport slave (
    input  REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1, M_RDATA,
    output GNT0, GNT1, RVALID0, RVALID1, RDATA, BUSY,
    output M_ADDR, M_CE, M_CSB, M_WEB, M_OEB, M_IDATA
  );

  modport master (
    output REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1, M_RDATA,
    input  GNT0, GNT1, RVALID0, RVALID1, RDATA, BUSY,
    input  M_ADDR, M_CE, M_CSB, M_WEB, M_OEB, M_IDATA
  );
endinterface

// File: rtl/mem_bank_arbiter.sv
// Two-port round-robin arbiter and single-byte transaction sequencer for the
// 4-bank SRAM front-end. All outputs are registered.
module mem_bank_arbiter #(
  parameter int unsigned LAT = 2
) (
  input logic              CLK,
  input logic              RSTN,
  mem_bank_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        port_q, port_d;
  logic        we_q, we_d;
  logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic        rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic [10:0] m_addr_q, m_addr_d;
  logic        m_ce_q, m_ce_d;
  logic        m_csb_q, m_csb_d;
  logic        m_web_q, m_web_d;
  logic        m_oeb_q, m_oeb_d;
  logic [7:0]  m_idata_q, m_idata_d;

  logic        win;
  logic        win_we;
  logic [10:0] win_addr;
  logic [7:0]  win_wdata;

  // With both ports requesting the pointer decides; otherwise the lone requester wins.
  assign win       = (bus.REQ0 && bus.REQ1) ? ptr_q : bus.REQ1;
  assign win_we    = win ? bus.WE1 : bus.WE0;
  assign win_addr  = win ? bus.ADDR1 : bus.ADDR0;
  assign win_wdata = win ? bus.WDATA1 : bus.WDATA0;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    port_d    = port_q;
    we_d      = we_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    rdata_d   = rdata_q;
    m_addr_d  = m_addr_q;
    m_idata_d = m_idata_q;
    m_ce_d    = 1'b0;
    m_csb_d   = 1'b1;
    m_web_d   = 1'b1;
    m_oeb_d   = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (bus.REQ0 || bus.REQ1) begin
          state_d   = StIssue;
          port_d    = win;
          we_d      = win_we;
          m_addr_d  = win_addr;
          m_idata_d = win_wdata;
          gnt0_d    = ~win;
          gnt1_d    = win;
          m_ce_d    = 1'b1;
          m_csb_d   = 1'b0;
          m_web_d   = ~win_we;
          m_oeb_d   = win_we;
        end
      end
      StIssue: begin
        state_d = StWait;
        ptr_d   = ~port_q;
        cnt_d   = 4'(LAT - 1);
        // Reads keep the bank selected and its output enabled while waiting.
        m_csb_d = we_q;
        m_oeb_d = we_q;
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
          if (!we_q) begin
            rdata_d   = bus.M_RDATA;
            rvalid0_d = ~port_q;
            rvalid1_d = port_q;
          end
        end else begin
          cnt_d   = cnt_q - 4'd1;
          m_csb_d = we_q;
          m_oeb_d = we_q;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= StIdle;
      ptr_q     <= 1'b0;
      cnt_q     <= 4'd0;
      port_q    <= 1'b0;
      we_q      <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata_q   <= 8'd0;
      busy_q    <= 1'b0;
      m_addr_q  <= 11'd0;
      m_ce_q    <= 1'b0;
      m_csb_q   <= 1'b1;
      m_web_q   <= 1'b1;
      m_oeb_q   <= 1'b1;
      m_idata_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      port_q    <= port_d;
      we_q      <= we_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      m_addr_q  <= m_addr_d;
      m_ce_q    <= m_ce_d;
      m_csb_q   <= m_csb_d;
      m_web_q   <= m_web_d;
      m_oeb_q   <= m_oeb_d;
      m_idata_q <= m_idata_d;
    end
  end

  assign bus.GNT0    = gnt0_q;
  assign bus.GNT1    = gnt1_q;
  assign bus.RVALID0 = rvalid0_q;
  assign bus.RVALID1 = rvalid1_q;
  assign bus.RDATA   = rdata_q;
  assign bus.BUSY    = busy_q;
  assign bus.M_ADDR  = m_addr_q;
  assign bus.M_CE    = m_ce_q;
  assign bus.M_CSB   = m_csb_q;
  assign bus.M_WEB   = m_web_q;
  assign bus.M_OEB   = m_oeb_q;
  assign bus.M_IDATA = m_idata_q;

endmodule
